sobel_out_fmt: RTL and testbench
================================

Name: sobel_out_fmt

Overview:
Parametrised output stage of the Sobel stream pipeline. It sits between the magnitude stage and the byte unpacker/UART TX. It takes one wide magnitude per pixel and tracks the pixel's frame position. It zeroes a configurable border, applies a runtime-selectable output mode, and serialises each pixel into CHANNELS_P bytes with frame markers. It replaces the fixed truncate-and-replicate-to-24-bit path.

Parameters:
WIDTH_P, 8, output pixel width in bits; the input magnitude is 2*WIDTH_P bits.
LINE_W_P, 640, pixels per line; must be at least 2*BORDER_P+1.
FRAME_H_P, 480, lines per frame; must be at least 2*BORDER_P+1.
CHANNELS_P, 3, output beats per pixel; range 1..4.
BORDER_P, 1, width in pixels of the frame border that is forced to zero; 0 disables border zeroing.

Ports:
clk_i  in  1  core clock
rst_i  in  1  asynchronous active-high reset
valid_i  in  1  input pixel valid
ready_o  out  1  input pixel ready
mag_i  in  2*WIDTH_P  unsigned gradient magnitude
sof_i  in  1  marks the input pixel as pixel (0,0); resyncs the position counters
mode_i  in  2  output mode; sampled when a pixel is accepted
thresh_i  in  WIDTH_P  binary-mode threshold; sampled when a pixel is accepted
valid_o  out  1  output beat valid
ready_i  in  1  downstream ready
data_o  out  WIDTH_P  output beat
sof_o  out  1  first beat of pixel (0,0)
eol_o  out  1  last beat of the last pixel of a line
eof_o  out  1  last beat of the last pixel of a frame

Behaviour:
- Reset (rst_i asynchronous, active-high): valid_o=0, data_o=0, sof_o=eol_o=eof_o=0, col=0, row=0, state=IDLE, so ready_o=1.
- Reset mid-pixel drops the remaining beats; no partial pixel is emitted after reset is released.
- Handshakes:
  - An input pixel is accepted on valid_i&&ready_o.
  - An output beat is transferred on valid_o&&ready_i.
  - Once valid_o is asserted, data_o and the marker outputs stay stable until the beat is transferred.
- Saturation: sat = (mag_i > 2^WIDTH_P-1) ? all-ones : mag_i[WIDTH_P-1:0].
- Modes, with mode_i latched at accept:
  - 0 SAT: out = sat.
  - 1 BIN: out = (sat >= thresh) ? all-ones : 0.
  - 2 INV: out = ~sat.
  - 3 RAW: out = mag_i[WIDTH_P-1:0], truncated, kept for legacy compatibility.
- Border: if BORDER_P>0 and (col<BORDER_P, or col>=LINE_W_P-BORDER_P, or row<BORDER_P, or row>=FRAME_H_P-BORDER_P), then out=0 in every mode, including INV.
- Position counters:
  - On accept, the position used for the pixel is (0,0) when sof_i=1; otherwise it is the current (col,row).
  - After accept: col increments; at LINE_W_P-1 it wraps to 0 and row increments; at FRAME_H_P-1 with col=LINE_W_P-1, both wrap to 0.
  - sof_i asserted mid-frame truncates the frame silently; no error output.
- State machine:
  - IDLE: ready_o=1. On accept, latch out and the markers, set beat=0, go to EMIT.
  - EMIT: valid_o=1 and data_o=out for every beat.
  - Last beat is beat==CHANNELS_P-1.
  - Non-last beat transferred: beat increments.
  - Last beat transferred: go to IDLE, or stay in EMIT if a new pixel is accepted in the same cycle.
- ready_o = (state==IDLE) || (state==EMIT && last beat && ready_i). This gives back-to-back pixels with no bubble and full throughput of 1 beat per cycle when CHANNELS_P=1.
- Latency: the first beat is valid the cycle after accept.
- Markers:
  - sof_o is 1 only on beat 0 of pixel (0,0).
  - eol_o and eof_o are 1 only on the last beat of the relevant pixel; at frame end eol_o and eof_o are both 1.
  - When CHANNELS_P=1, sof_o and eol_o can coincide with other markers on the same beat.
- Simultaneous events: a last-beat transfer and a new accept in the same cycle load the new pixel with beat=0; no beat is lost or duplicated.
- ready_i low during EMIT holds all outputs, and ready_o stays 0.

Decomposition:
- Package sobel_pkg:
  - mode_e enum (MODE_SAT, MODE_BIN, MODE_INV, MODE_RAW).
  - fmt_state_e (IDLE, EMIT).
  - Width constants COL_W=$clog2(LINE_W_P), ROW_W=$clog2(FRAME_H_P), BEAT_W=$clog2(CHANNELS_P) floored to 1.
- Sub-module sobel_pos_cnt: column/row counter with inc, resync-to-zero, wrap, and the is_border/is_eol/is_eof outputs.
- The formatter, FSM and beat counter live in the top module.

Test Plan:
All scenarios use LINE_W_P=4, FRAME_H_P=3, BORDER_P=1, CHANNELS_P=3 unless stated otherwise.
- Reset, then stream 12 pixels with mag_i=16'h0040, mode=SAT, ready_i=1 -> 36 beats.
  - Only pixels (1,1) and (2,1) emit 0x40 on all 3 beats; every other beat is 0x00.
  - sof_o is set on beat 0 of pixel 0.
  - eol_o is set on beat 2 of pixels 3, 7 and 11; eof_o on beat 2 of pixel 11 only.
- Interior pixel with mag_i=16'h0123, mode SAT -> 0xFF; mode RAW -> 0x23; mode INV -> 0x00.
- Interior pixel in mode BIN with thresh=0x80: mag 0x7F -> 0x00; mag 0x80 -> 0xFF.
  - A border pixel in BIN mode with mag 0xFFFF -> 0x00.
- Randomised ready_i (50%), 100 pixels -> zero lost or duplicated beats, data stable while stalled.
  - With ready_i=1 throughout, ready_o is high on exactly one cycle in three, with no idle bubble.
- sof_i asserted on pixel 5 of a frame -> that pixel's beat 0 carries sof_o=1, and the counters restart at (0,0) for it.
- rst_i asserted after beat 1 of an interior pixel -> valid_o=0 immediately (asynchronously), ready_o=1 after release, next output is beat 0 of a new pixel at (0,0).
- CHANNELS_P=1, BORDER_P=0 -> 1 beat per cycle of sustained throughput; all pixels pass through unzeroed.

Source files
------------

// File: rtl/sobel_pkg.sv
// Shared types and width helpers for the Sobel output stage.
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_SAT = 2'd0,
    MODE_BIN = 2'd1,
    MODE_INV = 2'd2,
    MODE_RAW = 2'd3
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } fmt_state_e;

  // Counter width for a range of n values, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sobel_pos_cnt.sv
// Column/row position tracker for the pixel stream. The position reported
// is the one the current input pixel would take if accepted now: sof_i
// forces it to (0,0), otherwise it is the stored count.
module sobel_pos_cnt
  import sobel_pkg::*;
#(
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480,
  parameter int BORDER_P  = 1,
  parameter int COL_W     = width_of(LINE_W_P),
  parameter int ROW_W     = width_of(FRAME_H_P)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic sof_i,
  output logic is_sof_o,
  output logic is_border_o,
  output logic is_eol_o,
  output logic is_eof_o
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W_P - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H_P - 1);

  logic [COL_W-1:0] col_q, col_d, col;
  logic [ROW_W-1:0] row_q, row_d, row;

  // Effective position of the pixel on the input: sof_i resyncs to origin.
  always_comb begin
    col = sof_i ? '0 : col_q;
    row = sof_i ? '0 : row_q;
  end

  // Advance from the effective position, wrapping at line and frame end.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (inc_i) begin
      if (col == COL_LAST) begin
        col_d = '0;
        row_d = (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col_d = col + 1'b1;
        row_d = row;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign is_sof_o = (col == '0) && (row == '0);
  assign is_eol_o = (col == COL_LAST);
  assign is_eof_o = (col == COL_LAST) && (row == ROW_LAST);

  generate
    if (BORDER_P > 0) begin : g_border
      localparam logic [COL_W-1:0] COL_LO = COL_W'(BORDER_P);
      localparam logic [COL_W-1:0] COL_HI = COL_W'(LINE_W_P - BORDER_P);
      localparam logic [ROW_W-1:0] ROW_LO = ROW_W'(BORDER_P);
      localparam logic [ROW_W-1:0] ROW_HI = ROW_W'(FRAME_H_P - BORDER_P);
      assign is_border_o = (col < COL_LO) || (col >= COL_HI) ||
                           (row < ROW_LO) || (row >= ROW_HI);
    end else begin : g_no_border
      assign is_border_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/sobel_out_fmt.sv
// Sobel output stage: saturates the wide magnitude, applies the selected
// output mode and border zeroing, then serialises each pixel into
// CHANNELS_P identical beats carrying sof/eol/eof frame markers.
module sobel_out_fmt
  import sobel_pkg::*;
#(
  parameter int WIDTH_P    = 8,
  parameter int LINE_W_P   = 640,
  parameter int FRAME_H_P  = 480,
  parameter int CHANNELS_P = 3,
  parameter int BORDER_P   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [2*WIDTH_P-1:0]   mag_i,
  input  logic                   sof_i,
  input  logic [1:0]             mode_i,
  input  logic [WIDTH_P-1:0]     thresh_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [WIDTH_P-1:0]     data_o,
  output logic                   sof_o,
  output logic                   eol_o,
  output logic                   eof_o
);

  localparam int COL_W  = width_of(LINE_W_P);
  localparam int ROW_W  = width_of(FRAME_H_P);
  localparam int BEAT_W = width_of(CHANNELS_P);
  localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(CHANNELS_P - 1);
  localparam logic [WIDTH_P-1:0] ONES      = '1;

  generate
    if (CHANNELS_P < 1 || CHANNELS_P > 4) begin : g_bad_ch
      $error("sobel_out_fmt: CHANNELS_P must be 1..4");
    end
    if (LINE_W_P < 2*BORDER_P+1 || FRAME_H_P < 2*BORDER_P+1) begin : g_bad_dim
      $error("sobel_out_fmt: frame too small for border");
    end
  endgenerate

  // Latched pixel: formatted value plus which markers it carries.
  typedef struct packed {
    logic [WIDTH_P-1:0] data;
    logic               sof;
    logic               eol;
    logic               eof;
  } pix_t;

  fmt_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  pix_t              pix_q, pix_d;

  logic               accept, last_beat;
  logic               is_sof, is_border, is_eol, is_eof;
  logic [WIDTH_P-1:0] sat, fmt;
  mode_e              mode;

  sobel_pos_cnt #(
    .LINE_W_P  (LINE_W_P),
    .FRAME_H_P (FRAME_H_P),
    .BORDER_P  (BORDER_P),
    .COL_W     (COL_W),
    .ROW_W     (ROW_W)
  ) u_pos (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_i       (accept),
    .sof_i       (sof_i),
    .is_sof_o    (is_sof),
    .is_border_o (is_border),
    .is_eol_o    (is_eol),
    .is_eof_o    (is_eof)
  );

  assign last_beat = (beat_q == BEAT_LAST);
  assign valid_o   = (state_q == EMIT);
  // Accept while idle, or under a completing last beat so pixels chain
  // without a bubble.
  assign ready_o   = (state_q == IDLE) || (valid_o && last_beat && ready_i);
  assign accept    = valid_i && ready_o;
  assign mode      = mode_e'(mode_i);

  // Saturate, apply mode, then force border pixels to zero in every mode.
  always_comb begin
    sat = (mag_i[2*WIDTH_P-1:WIDTH_P] != '0) ? ONES : mag_i[WIDTH_P-1:0];
    fmt = sat;
    case (mode)
      MODE_SAT: fmt = sat;
      MODE_BIN: fmt = (sat >= thresh_i) ? ONES : '0;
      MODE_INV: fmt = ~sat;
      MODE_RAW: fmt = mag_i[WIDTH_P-1:0];
    endcase
    if (is_border) fmt = '0;
  end

  // Next-state for the emit FSM, beat counter and pixel latch.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    pix_d   = pix_q;
    if (accept) begin
      state_d   = EMIT;
      beat_d    = '0;
      pix_d.data = fmt;
      pix_d.sof = is_sof;
      pix_d.eol = is_eol;
      pix_d.eof = is_eof;
    end else if (valid_o && ready_i) begin
      if (last_beat) state_d = IDLE;
      else           beat_d  = beat_q + 1'b1;
    end
  end

  // State registers; reset drops any pixel in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      pix_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      pix_q   <= pix_d;
    end
  end

  assign data_o = pix_q.data;
  assign sof_o  = valid_o && pix_q.sof && (beat_q == '0);
  assign eol_o  = valid_o && pix_q.eol && last_beat;
  assign eof_o  = valid_o && pix_q.eof && last_beat;

endmodule

// File: tb/tb_sobel_out_fmt.sv
// Bench for sobel_out_fmt: scoreboard against a frame-level model for a
// 4x3 frame with 3 beats/pixel, plus a 1-beat, no-border throughput check.
module tb_sobel_out_fmt;

  localparam int LW = 4, FH = 3, CH = 3, B = 1;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic        valid_i, ready_o, sof_i, ready_i, valid_o, sof_o, eol_o, eof_o;
  logic [15:0] mag_i;
  logic [1:0]  mode_i;
  logic [7:0]  thresh_i, data_o;

  logic        v1_i, r1_o, s1_i, rdy1_i, v1_o, sof1_o, eol1_o, eof1_o;
  logic [15:0] mag1_i;
  logic [1:0]  mode1_i;
  logic [7:0]  thr1_i, d1_o;

  sobel_out_fmt #(.WIDTH_P(8), .LINE_W_P(LW), .FRAME_H_P(FH), .CHANNELS_P(CH), .BORDER_P(B)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .mag_i(mag_i),
    .sof_i(sof_i), .mode_i(mode_i), .thresh_i(thresh_i), .valid_o(valid_o), .ready_i(ready_i),
    .data_o(data_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o));

  sobel_out_fmt #(.WIDTH_P(8), .LINE_W_P(LW), .FRAME_H_P(FH), .CHANNELS_P(1), .BORDER_P(0)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .valid_i(v1_i), .ready_o(r1_o), .mag_i(mag1_i),
    .sof_i(s1_i), .mode_i(mode1_i), .thresh_i(thr1_i), .valid_o(v1_o), .ready_i(rdy1_i),
    .data_o(d1_o), .sof_o(sof1_o), .eol_o(eol1_o), .eof_o(eof1_o));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  typedef struct { logic [15:0] mag; logic [1:0] mode; logic [7:0] thr; logic sof; } pix_t;
  typedef struct { logic [7:0] data; logic sof; logic eol; logic eof; } beat_t;

  pix_t  send_q[$];
  beat_t exp_q[$];
  int    mcol = 0, mrow = 0;
  bit    hold_v, acc_now;
  logic [10:0] held;
  int    bubbles, rdy_emit, vld_cyc, xfers;
  int    rdy_pct = 100, vld_pct = 100;

  // Frame-level model: what beats one accepted pixel must produce.
  task automatic model_accept(input pix_t p);
    int s, v;
    bit border;
    beat_t bt;
    if (p.sof) begin mcol = 0; mrow = 0; end
    border = (mcol < B) || (mcol >= LW-B) || (mrow < B) || (mrow >= FH-B);
    s = (p.mag > 255) ? 255 : int'(p.mag);
    case (p.mode)
      2'd0: v = s;
      2'd1: v = (s >= int'(p.thr)) ? 255 : 0;
      2'd2: v = 255 - s;
      default: v = int'(p.mag) % 256;
    endcase
    if (border) v = 0;
    for (int b = 0; b < CH; b++) begin
      bt.data = v[7:0];
      bt.sof  = (mcol == 0) && (mrow == 0) && (b == 0);
      bt.eol  = (b == CH-1) && (mcol == LW-1);
      bt.eof  = (b == CH-1) && (mcol == LW-1) && (mrow == FH-1);
      exp_q.push_back(bt);
    end
    mcol++;
    if (mcol == LW) begin
      mcol = 0;
      mrow++;
      if (mrow == FH) mrow = 0;
    end
  endtask

  // Observe at the falling edge: what transfers on the next rising edge.
  task automatic monitor();
    logic [10:0] now;
    beat_t e;
    now = {data_o, sof_o, eol_o, eof_o};
    if (hold_v) begin
      chk("hold_valid", valid_o, 1);
      chk("hold_beat", now, held);
    end
    hold_v = valid_o && !ready_i;
    held   = now;
    if (!valid_o && exp_q.size() > 0) bubbles++;
    if (valid_o) vld_cyc++;
    if (valid_o && ready_o) rdy_emit++;
    if (valid_o && ready_i) begin
      xfers++;
      chk("beat_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("data", data_o, e.data);
        chk("sof", sof_o, e.sof);
        chk("eol", eol_o, e.eol);
        chk("eof", eof_o, e.eof);
      end
    end
    acc_now = valid_i && ready_o;
    if (acc_now) model_accept(send_q.pop_front());
  endtask

  // Present the head pixel (held until accepted) and a fresh ready_i.
  task automatic drive();
    if (acc_now || !valid_i) begin
      if (send_q.size() > 0 && $urandom_range(99) < vld_pct) begin
        valid_i  = 1'b1;
        mag_i    = send_q[0].mag;
        mode_i   = send_q[0].mode;
        thresh_i = send_q[0].thr;
        sof_i    = send_q[0].sof;
      end else begin
        valid_i = 1'b0;
        sof_i   = 1'b0;
      end
    end
    ready_i = ($urandom_range(99) < rdy_pct);
    acc_now = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((send_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_left", send_q.size() + exp_q.size(), 0);
  endtask

  task automatic push_pix(input logic [15:0] m, input logic [1:0] md, input logic [7:0] t, input logic s);
    pix_t p;
    p.mag = m; p.mode = md; p.thr = t; p.sof = s;
    send_q.push_back(p);
  endtask

  function automatic logic [15:0] rnd_mag();
    return ($urandom_range(1) == 0) ? 16'($urandom_range(511)) : 16'($urandom);
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] m1 [24];
    int e1;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sof_i = 1'b0;
    mag_i = '0; mode_i = '0; thresh_i = '0;
    v1_i = 1'b0; s1_i = 1'b0; rdy1_i = 1'b1; mag1_i = '0; mode1_i = 2'd0; thr1_i = '0;
    #3;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_markers", {sof_o, eol_o, eof_o}, 0);
    chk("rst_ready", ready_o, 1);
    @(posedge clk); #1;
    rst_i = 1'b0;
    chk("post_rst_ready", ready_o, 1);
    chk("post_rst_valid", valid_o, 0);

    // Full frame of 0x40 in SAT mode: only the two interior pixels pass.
    for (int i = 0; i < 12; i++) push_pix(16'h0040, 2'd0, 8'h00, 1'b0);
    bubbles = 0; rdy_emit = 0; vld_cyc = 0;
    drive();
    drain(200);
    chk("frame_bubbles", bubbles, 0);
    chk("frame_valid_cycles", vld_cyc, 36);
    chk("frame_ready_cycles", rdy_emit, 12);

    // Directed mode values on interior pixels (1,1) and (2,1).
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 12; i++) begin
        if (f == 0 && i == 5)      push_pix(16'h0123, 2'd0, 8'h00, 1'b0);
        else if (f == 0 && i == 6) push_pix(16'h0123, 2'd3, 8'h00, 1'b0);
        else if (f == 1 && i == 5) push_pix(16'h0123, 2'd2, 8'h00, 1'b0);
        else if (f == 1 && i == 6) push_pix(16'h007F, 2'd1, 8'h80, 1'b0);
        else if (f == 2 && i == 0) push_pix(16'hFFFF, 2'd1, 8'h00, 1'b0);
        else if (f == 2 && i == 5) push_pix(16'h0080, 2'd1, 8'h80, 1'b0);
        else if (f == 3 && i == 5) push_pix(16'h0040, 2'd0, 8'h00, 1'b1);
        else push_pix(rnd_mag(), 2'($urandom_range(3)), 8'($urandom), 1'b0);
      end
    end
    drive();
    drain(400);

    // Random stream with stalls on both sides and occasional resync.
    rdy_pct = 50; vld_pct = 70; xfers = 0;
    for (int i = 0; i < 100; i++)
      push_pix(rnd_mag(), 2'($urandom_range(3)), 8'($urandom), ($urandom_range(19) == 0));
    drive();
    drain(2000);
    chk("rand_beats", xfers, 300);
    chk("rand_bubbles", bubbles, 0);

    // Reset in the middle of interior pixel (1,1), after its beat 1.
    rdy_pct = 100; vld_pct = 100;
    push_pix(16'h0040, 2'd0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) push_pix(16'h0040, 2'd0, 8'h00, 1'b0);
    drive();
    begin
      int n = 0;
      while (!(send_q.size() == 0 && exp_q.size() == 1) && n < 100) begin
        step();
        n++;
      end
      chk("reach_beat2", exp_q.size(), 1);
    end
    #2;
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", valid_o, 0);
    chk("async_rst_data", data_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    exp_q.delete();
    mcol = 0; mrow = 0; hold_v = 1'b0; acc_now = 1'b0;
    chk("rel_ready", ready_o, 1);
    chk("rel_valid", valid_o, 0);
    push_pix(16'h0040, 2'd0, 8'h00, 1'b0);
    drive();
    drain(50);

    // One beat per pixel, no border: one pixel per cycle, unmodified.
    for (int k = 0; k < 24; k++) m1[k] = rnd_mag();
    for (int k = 0; k <= 24; k++) begin
      @(posedge clk); #1;
      v1_i   = (k < 24);
      mag1_i = (k < 24) ? m1[k] : 16'h0;
      @(negedge clk);
      if (k < 24) chk("thru_ready", r1_o, 1);
      if (k > 0) begin
        e1 = (m1[k-1] > 255) ? 255 : int'(m1[k-1]);
        chk("thru_valid", v1_o, 1);
        chk("thru_data", d1_o, e1[7:0]);
        chk("thru_sof", sof1_o, ((k-1) % 12) == 0);
        chk("thru_eol", eol1_o, ((k-1) % 4) == 3);
        chk("thru_eof", eof1_o, ((k-1) % 12) == 11);
      end
    end
    @(posedge clk); #1;
    v1_i = 1'b0;
    @(negedge clk);
    chk("thru_idle", v1_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
